// File: rtl/mult_entry_ctrl.sv
// Keypad operand entry sequencer for the multiplier: builds two decimal operands,
// pulses the multiplier start, waits for done (with timeout) and holds the product.
module mult_entry_ctrl #(
  parameter int N_DIGITS    = 2,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid_i,
  input  logic [3:0]           key_i,
  input  logic                 mult_done_i,
  input  logic [2*WIDTH-1:0]   product_i,
  output logic [WIDTH-1:0]     op_a_o,
  output logic [WIDTH-1:0]     op_b_o,
  output logic                 mult_start_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 result_valid_o,
  output logic [2:0]           state_o,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_DIGITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // The largest N_DIGITS-digit decimal value must fit in an operand.
  if ((longint'(10) ** N_DIGITS) - 1 >= (longint'(1) << WIDTH)) begin : g_width_check
    $error("mult_entry_ctrl: WIDTH too small for N_DIGITS decimal digits");
  end

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;

  logic is_digit, is_enter, is_clear;

  // op*10 + digit without a multiplier.
  function automatic logic [WIDTH-1:0] accum(input logic [WIDTH-1:0] op,
                                             input logic [3:0] digit);
    return (op << 3) + (op << 1) + WIDTH'(digit);
  endfunction

  assign is_digit = key_valid_i && (key_i <= 4'd9);
  assign is_enter = key_valid_i && (key_i == 4'd10);
  assign is_clear = key_valid_i && (key_i == 4'd11);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_ENTER_A: begin
        if (is_digit) begin
          if (cnt_q < CNT_MAX) begin
            op_a_d = accum(op_a_q, key_i);
            cnt_d  = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_enter) begin
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            op_b_d  = '0;
            cnt_d   = '0;
            state_d = S_ENTER_B;
          end
        end else if (is_clear) begin
          op_a_d = '0;
          cnt_d  = '0;
        end
      end
      S_ENTER_B: begin
        if (is_digit) begin
          if (cnt_q < CNT_MAX) begin
            op_b_d = accum(op_b_q, key_i);
            cnt_d  = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_enter) begin
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_START;
            start_d = 1'b1;
          end
        end else if (is_clear) begin
          if (cnt_q != '0) begin
            op_b_d = '0;
            cnt_d  = '0;
          end else begin
            op_a_d  = '0;
            state_d = S_ENTER_A;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over both the timeout and any key in the same cycle.
        if (mult_done_i) begin
          result_d = product_i;
          state_d  = S_SHOW;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          op_a_d  = '0;
          op_b_d  = '0;
          cnt_d   = '0;
          state_d = S_ENTER_A;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (is_digit) begin
          op_a_d   = WIDTH'(key_i);
          op_b_d   = '0;
          cnt_d    = CNT_W'(1);
          result_d = '0;
          state_d  = S_ENTER_A;
        end else if (is_clear) begin
          op_a_d   = '0;
          op_b_d   = '0;
          cnt_d    = '0;
          result_d = '0;
          state_d  = S_ENTER_A;
        end
      end
      default: state_d = S_ENTER_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_ENTER_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  assign op_a_o         = op_a_q;
  assign op_b_o         = op_b_q;
  assign mult_start_o   = start_q;
  assign result_o       = result_q;
  assign err_o          = err_q;
  assign state_o        = state_q;
  assign result_valid_o = (state_q == S_SHOW);

endmodule

// File: tb/tb_mult_entry_ctrl.sv
// Scoreboard bench for mult_entry_ctrl: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them and tallies start/err pulses.
module tb_mult_entry_ctrl;

  localparam int N_DIGITS    = 2;
  localparam int WIDTH       = 8;
  localparam int TIMEOUT_CYC = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 key_valid_i;
  logic [3:0]           key_i;
  logic                 mult_done_i;
  logic [2*WIDTH-1:0]   product_i;
  logic [WIDTH-1:0]     op_a_o;
  logic [WIDTH-1:0]     op_b_o;
  logic                 mult_start_o;
  logic [2*WIDTH-1:0]   result_o;
  logic                 result_valid_o;
  logic [2:0]           state_o;
  logic                 err_o;

  mult_entry_ctrl #(
    .N_DIGITS(N_DIGITS), .WIDTH(WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .key_valid_i(key_valid_i), .key_i(key_i),
    .mult_done_i(mult_done_i), .product_i(product_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o),
    .mult_start_o(mult_start_o),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .state_o(state_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  st;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        rv;
    logic        err;
    logic        start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   exp_err = 0;
  int   exp_start = 0;
  int   obs_err = 0;
  int   obs_start = 0;
  int   dbl_start = 0;
  logic start_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops snapshots due this cycle and compares all outputs.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (err_o) obs_err++;
    if (mult_start_o) begin
      obs_start++;
      if (start_prev) dbl_start++;
    end
    start_prev = mult_start_o;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc == cyc && state_o === e.st && op_a_o === e.a && op_b_o === e.b &&
          result_o === e.res && result_valid_o === e.rv && err_o === e.err &&
          mult_start_o === e.start) begin
        passed++;
      end else begin
        $display("FAIL %s: got st=%0d a=%0d b=%0d res=%0d rv=%b err=%b start=%b cyc=%0d, want st=%0d a=%0d b=%0d res=%0d rv=%b err=%b start=%b cyc=%0d",
                 e.nm, state_o, op_a_o, op_b_o, result_o, result_valid_o, err_o, mult_start_o, cyc,
                 e.st, e.a, e.b, e.res, e.rv, e.err, e.start, e.cyc);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [2:0] st, input int a, input int b,
                            input int res, input bit err, input bit start);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.st = st; e.a = 8'(a); e.b = 8'(b); e.res = 16'(res);
    e.rv = (st == 3'd4); e.err = err; e.start = start;
    if (err) exp_err++;
    if (start) exp_start++;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, sampled at the next edge; returns #1 after that edge.
  task automatic step(input bit kv, input logic [3:0] k, input bit dv, input int p);
    key_valid_i = kv; key_i = k; mult_done_i = dv; product_i = 16'(p);
    @(posedge clk); #1;
    key_valid_i = 1'b0; key_i = 4'd0; mult_done_i = 1'b0; product_i = '0;
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0, 0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 0);
  endtask

  task automatic final_check(input string nm, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; key_valid_i = 1'b0; key_i = 4'd0; mult_done_i = 1'b0; product_i = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // 42 x 15
    key(4);  expect_out("a_4", 0, 4, 0, 0, 0, 0);
    key(2);  expect_out("a_42", 0, 42, 0, 0, 0, 0);
    key(10); expect_out("to_b", 1, 42, 0, 0, 0, 0);
    key(1);  expect_out("b_1", 1, 42, 1, 0, 0, 0);
    key(5);  expect_out("b_15", 1, 42, 15, 0, 0, 0);
    key(10); expect_out("start", 2, 42, 15, 0, 0, 1);
    idle();  expect_out("wait", 3, 42, 15, 0, 0, 0);
    step(1'b0, 4'd0, 1'b1, 630); expect_out("show", 4, 42, 15, 630, 0, 0);
    key(7);  expect_out("show_digit7", 0, 7, 0, 0, 0, 0);

    // Digit overflow and empty enters
    key(11); expect_out("clr_a", 0, 0, 0, 0, 0, 0);
    key(9);
    key(9);  expect_out("a_99", 0, 99, 0, 0, 0, 0);
    key(9);  expect_out("a_third9", 0, 99, 0, 0, 1, 0);
    key(10); expect_out("to_b2", 1, 99, 0, 0, 0, 0);
    key(10); expect_out("b_empty_enter", 1, 99, 0, 0, 1, 0);
    key(3);  expect_out("b_3", 1, 99, 3, 0, 0, 0);
    key(15); expect_out("b_key15", 1, 99, 3, 0, 0, 0);
    key(11); expect_out("b_clear", 1, 99, 0, 0, 0, 0);
    key(11); expect_out("b_clear_back", 0, 0, 0, 0, 0, 0);
    key(12); expect_out("a_key12", 0, 0, 0, 0, 0, 0);
    step(1'b0, 4'd0, 1'b1, 1234); expect_out("done_in_a", 0, 0, 0, 0, 0, 0);
    key(10); expect_out("a_empty_enter", 0, 0, 0, 0, 1, 0);

    // Timeout: 12 x 3, no done
    key(1); key(2); key(10); key(3);
    key(10); expect_out("start2", 2, 12, 3, 0, 0, 1);
    idle();  expect_out("wait2", 3, 12, 3, 0, 0, 0);
    key(5);  expect_out("wait_key_ignored", 3, 12, 3, 0, 0, 0);
    repeat (TIMEOUT_CYC - 2) @(posedge clk);
    #1;      expect_out("wait_last_cycle", 3, 12, 3, 0, 0, 0);
    idle();  expect_out("timeout", 0, 0, 0, 0, 1, 0);

    // Done arriving in the timeout cycle wins
    key(2); key(10); key(3);
    key(10); expect_out("start3", 2, 2, 3, 0, 0, 1);
    idle();  expect_out("wait3", 3, 2, 3, 0, 0, 0);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    #1;
    step(1'b0, 4'd0, 1'b1, 6); expect_out("done_at_timeout", 4, 2, 3, 6, 0, 0);
    key(11); expect_out("show_clear", 0, 0, 0, 0, 0, 0);

    // Done and key together
    key(5); key(10); key(6);
    key(10); expect_out("start4", 2, 5, 6, 0, 0, 1);
    idle();  expect_out("wait4", 3, 5, 6, 0, 0, 0);
    step(1'b1, 4'd7, 1'b1, 30); expect_out("done_with_key", 4, 5, 6, 30, 0, 0);
    key(10); expect_out("show_enter", 4, 5, 6, 30, 0, 0);
    key(8);  expect_out("show_digit8", 0, 8, 0, 0, 0, 0);

    // Reset mid-WAIT
    key(10); key(2);
    key(10); expect_out("start5", 2, 8, 2, 0, 0, 1);
    idle();  expect_out("wait5", 3, 8, 2, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_out("reset_in_wait", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle();  expect_out("after_reset", 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    final_check("scoreboard_drained", sb.size(), 0);
    final_check("err_pulse_count", obs_err, exp_err);
    final_check("start_pulse_count", obs_start, exp_start);
    final_check("start_back_to_back", dbl_start, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_entry_ctrl.md
Name: mult_entry_ctrl

Overview:
- Sequences keypad operand entry for the multiplier.
- Takes decoded key codes from the keypad decoder stage and accumulates two decimal operands in binary.
- Pulses the multiplier start, waits for its done, then holds the product for the display stage.
- Sits between the keypad decoder and the multiplier datapath; it is the only block that drives multiplier start.

Parameters:
- N_DIGITS, 2, maximum decimal digits per operand.
- WIDTH, 8, operand width in bits. Elaboration must enforce 10^N_DIGITS - 1 < 2^WIDTH.
- TIMEOUT_CYC, 1024, maximum cycles to wait for mult_done_i before aborting.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- key_valid_i  in  1  single-cycle pulse; key_i is valid this cycle.
- key_i  in  4  0-9 = digit, 10 = enter (#), 11 = clear (*), 12-15 = ignored (15 is decoder error).
- mult_done_i  in  1  single-cycle pulse from the multiplier; product_i is valid this cycle.
- product_i  in  2*WIDTH  multiplier result.
- op_a_o  out  WIDTH  operand A (binary).
- op_b_o  out  WIDTH  operand B (binary).
- mult_start_o  out  1  single-cycle start pulse.
- result_o  out  2*WIDTH  latched product.
- result_valid_o  out  1  high while in SHOW.
- state_o  out  3  0 = ENTER_A, 1 = ENTER_B, 2 = START, 3 = WAIT, 4 = SHOW; drives display mux.
- err_o  out  1  single-cycle pulse on a rejected key or timeout.

Behaviour:
- Reset (rst = 0 at a clk edge): state ENTER_A; all outputs, operands, digit counter and timeout counter are 0. Reset has priority in every state, including mid-WAIT.
- All registers are updated on posedge clk. Outputs are registered, except that state_o and result_valid_o decode the state register.
- Accumulate rule: op <= op*10 + digit, computed as (op<<3) + (op<<1) + digit at WIDTH bits. The parameter constraint guarantees no overflow.
- ENTER_A:
  - Digit, cnt < N_DIGITS: accumulate into op_a, cnt++.
  - Digit, cnt == N_DIGITS: ignored, err_o pulse.
  - Enter, cnt == 0: err_o pulse, stay.
  - Enter, cnt > 0: op_b <= 0, cnt <= 0, go to ENTER_B.
  - Clear: op_a <= 0, cnt <= 0.
- ENTER_B:
  - Digits: same rules as ENTER_A, applied to op_b.
  - Enter, cnt > 0: go to START.
  - Enter, cnt == 0: err_o pulse.
  - Clear, cnt > 0: op_b <= 0, cnt <= 0.
  - Clear, cnt == 0: op_a <= 0, go to ENTER_A.
- START (exactly 1 cycle):
  - mult_start_o = 1; timeout counter cleared; next state WAIT.
  - op_a_o and op_b_o stay stable from START until SHOW is exited.
- WAIT:
  - All keys ignored, with no err_o.
  - mult_done_i: result_o <= product_i, go to SHOW.
  - Counter reaches TIMEOUT_CYC - 1 without done: err_o pulse, clear operands and cnt, go to ENTER_A.
  - Done and a key in the same cycle: done is taken, key dropped.
  - Done in the timeout cycle: done wins.
- SHOW:
  - result_valid_o = 1; result_o holds.
  - Digit d: op_a <= d, op_b <= 0, cnt <= 1, result_o <= 0, go to ENTER_A.
  - Clear: clear op_a, op_b, cnt, result_o; go to ENTER_A.
  - Enter: ignored.
- mult_done_i outside WAIT: ignored.
- Keys 12-15: ignored in every state, with no err_o.
- mult_start_o is never high for 2 consecutive cycles and is never high outside START.

Test Plan:
- Reset, then key pulses 4, 2, #, 1, 5, # -> op_a_o = 42 and op_b_o = 15; mult_start_o is high exactly 1 cycle; state_o goes 0→1→2→3.
- In WAIT, drive mult_done_i with product_i = 630 -> result_o = 630, result_valid_o = 1, state_o = 4. Then key 7 -> state_o = 0, op_a_o = 7, result_valid_o = 0.
- Keys 9, 9, 9 in ENTER_A -> op_a_o = 99 and err_o pulses once on the third 9. # with empty B -> err_o pulse, state stays 1.
- ENTER_B with op_b = 3: *, * -> first clears op_b to 0, second returns to state 0 with op_a_o = 0. Key 15 pulses anywhere -> no change and no err_o.
- Enter WAIT and never assert done -> after TIMEOUT_CYC cycles err_o pulses, state_o = 0, and operands are 0. Separately, assert rst = 0 mid-WAIT -> all outputs 0 next edge.
- Done and key in the same WAIT cycle -> SHOW with the product latched and the key dropped. Done pulses while in ENTER_A -> no effect.
